ddc_mixer: RTL and testbench
============================

DDC_MIXER -- requirements
Module: ddc_mixer

Interface
REQ-001 Parameter DW, 16, ADC sample width (signed two's complement).
REQ-002 Parameter NW, 16, NCO sine word width (signed two's complement).
REQ-003 Parameter OW, 16, mixer output width (signed); SHALL satisfy OW <= DW+NW-1.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 clken  input  1  clock enable; when low, all pipeline and flag state SHALL hold.
REQ-007 adc_i  input  DW  signed ADC sample.
REQ-008 adc_valid  input  1  adc_i qualifier.
REQ-009 nco_sin  input  NW  signed NCO sine sample (the NCO fsin_o output).
REQ-010 nco_valid  input  1  nco_sin qualifier (the NCO out_valid output).
REQ-011 ovf_clr  input  1  clears ovf_sticky and misalign_sticky; honoured only when clken=1.
REQ-012 mix_o  output  OW  signed, rounded, saturated product.
REQ-013 mix_valid  output  1  mix_o qualifier, one-cycle pulse per accepted pair.
REQ-014 ovf_sticky  output  1  set when any output saturated.
REQ-015 misalign_sticky  output  1  set when adc_valid != nco_valid in an enabled cycle.
REQ-016 mix_count  output  32  count of mix_valid pulses since reset, wraps 0xFFFFFFFF -> 0.

Function
REQ-017 An input pair SHALL be accepted only in a cycle with clken=1, adc_valid=1, nco_valid=1.
REQ-018 Pipeline: S1 registers operands + valid; S2 registers full product P = adc_i*nco_sin (DW+NW bits, signed); S3 registers rounded/saturated result + valid.
REQ-019 Latency SHALL be exactly 3 enabled clock edges from acceptance to mix_valid=1 with the result; non-enabled cycles SHALL not advance any stage.
REQ-020 Throughput: one accepted pair per enabled cycle, no bubbles inserted.
REQ-021 Rounding: R = (P + 2^(SH-1)) >>> SH, SH = DW+NW-1-OW (round half toward +infinity); with defaults SH=15.
REQ-022 Saturation: R > 2^(OW-1)-1 -> mix_o = 2^(OW-1)-1; R < -2^(OW-1) -> mix_o = -2^(OW-1); rounding add SHALL use a width that cannot wrap.
REQ-023 ovf_sticky SHALL set in the S3 cycle that saturates, and stay set until ovf_clr or reset.
REQ-024 misalign_sticky SHALL set when clken=1 and adc_valid XOR nco_valid; the unpaired sample is dropped, not buffered.
REQ-025 Set and ovf_clr in the same enabled cycle: set wins (flag = 1 after the edge).
REQ-026 mix_count SHALL increment on the same edge that asserts mix_valid.
REQ-027 mix_o SHALL hold its last value while mix_valid=0.

Reset
REQ-028 On reset_n=0 at a clock edge, regardless of clken: all pipeline valids, mix_valid, ovf_sticky, misalign_sticky = 0; mix_o = 0; mix_count = 0.
REQ-029 Pairs in flight at reset SHALL be discarded; first valid output after release requires a fresh acceptance plus 3 enabled edges.

Verification
REQ-030 adc_i=16384, nco_sin=16384, both valid, clken=1 -> mix_o=8192, mix_valid=1 exactly 3 edges later, mix_count=1.
REQ-031 adc_i=-32768, nco_sin=-32768 -> mix_o=32767, ovf_sticky=1; then ovf_clr=1 one cycle -> ovf_sticky=0.
REQ-032 adc_i=1,nco_sin=16384 -> mix_o=1; adc_i=-1,nco_sin=16384 -> mix_o=0 (half-up rounding check).
REQ-033 Accept pair, then clken=0 for 2 cycles after S1 -> mix_valid appears 5 clock edges after acceptance, value unchanged.
REQ-034 adc_valid=1, nco_valid=0 for one enabled cycle -> no mix_valid pulse, misalign_sticky=1, mix_count unchanged.
REQ-035 Continuous stream of 10 pairs, reset_n=0 after 4 accepted -> all outputs 0 next edge, no further mix_valid from pre-reset pairs, mix_count=0.

Source files
------------

// File: rtl/ddc_mixer.sv
// Digital down-converter mixer: multiplies ADC samples by the NCO sine word.
// The product is rounded half-up, saturated to OW bits and emitted through a
// three-stage pipeline that fully stalls whenever clken is low.
module ddc_mixer #(
    parameter int DW = 16,
    parameter int NW = 16,
    parameter int OW = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clken,
    input  logic signed [DW-1:0] adc_i,
    input  logic                 adc_valid,
    input  logic signed [NW-1:0] nco_sin,
    input  logic                 nco_valid,
    input  logic                 ovf_clr,
    output logic signed [OW-1:0] mix_o,
    output logic                 mix_valid,
    output logic                 ovf_sticky,
    output logic                 misalign_sticky,
    output logic [31:0]          mix_count
);

    localparam int PW   = DW + NW;
    localparam int SH   = PW - 1 - OW;
    localparam int SHM1 = (SH > 0) ? SH - 1 : 0;

    // One extra bit above the product so adding the rounding half cannot wrap.
    localparam logic signed [PW:0] ONE  = 1;
    localparam logic signed [PW:0] HALF = (SH > 0) ? (ONE <<< SHM1) : '0;
    localparam logic signed [PW:0] MAXV = {{(PW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [PW:0] MINV = {{(PW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};

    function automatic logic signed [PW:0] round_half_up(input logic signed [PW-1:0] p);
        logic signed [PW:0] s;
        s = {p[PW-1], p};
        s = s + HALF;
        return s >>> SH;
    endfunction

    function automatic logic is_sat(input logic signed [PW:0] r);
        return (r > MAXV) || (r < MINV);
    endfunction

    function automatic logic signed [OW-1:0] saturate(input logic signed [PW:0] r);
        if (r > MAXV)
            return {1'b0, {(OW - 1){1'b1}}};
        else if (r < MINV)
            return {1'b1, {(OW - 1){1'b0}}};
        else
            return r[OW-1:0];
    endfunction

    logic signed [DW-1:0] adc_p0;
    logic signed [NW-1:0] nco_p0;
    logic                 vld_p0;
    logic signed [PW-1:0] prod_p1;
    logic                 vld_p1;
    logic signed [PW:0]   rnd_p1;
    logic                 accept;
    logic                 misalign;

    assign accept   = adc_valid & nco_valid;
    assign misalign = adc_valid ^ nco_valid;
    assign rnd_p1   = round_half_up(prod_p1);

    // Datapath registers: operands (S1) and full-precision product (S2), no reset needed.
    always_ff @(posedge clk) begin
        if (clken) begin
            adc_p0  <= adc_i;
            nco_p0  <= nco_sin;
            prod_p1 <= adc_p0 * nco_p0;
        end
    end

    // S1/S2 valid pipeline; reset discards pairs in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (clken) begin
            vld_p0 <= accept;
            vld_p1 <= vld_p0;
        end
    end

    // S3 output stage: result only updates on a valid pair, otherwise holds.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mix_o     <= '0;
            mix_valid <= 1'b0;
            mix_count <= '0;
        end else if (clken) begin
            mix_valid <= vld_p1;
            if (vld_p1) begin
                mix_o     <= saturate(rnd_p1);
                mix_count <= mix_count + 32'd1;
            end
        end
    end

    // Sticky status flags; a new event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_sticky      <= 1'b0;
            misalign_sticky <= 1'b0;
        end else if (clken) begin
            if (vld_p1 && is_sat(rnd_p1))
                ovf_sticky <= 1'b1;
            else if (ovf_clr)
                ovf_sticky <= 1'b0;

            if (misalign)
                misalign_sticky <= 1'b1;
            else if (ovf_clr)
                misalign_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ddc_mixer.sv
// Scoreboard bench for ddc_mixer: stimulus pushes expected results computed
// from real-valued arithmetic; an independent monitor pops and compares.
module tb_ddc_mixer;

    localparam int DW = 16;
    localparam int NW = 16;
    localparam int OW = 16;
    localparam int SH = DW + NW - 1 - OW;

    logic                 clk;
    logic                 reset_n;
    logic                 clken;
    logic signed [DW-1:0] adc_i;
    logic                 adc_valid;
    logic signed [NW-1:0] nco_sin;
    logic                 nco_valid;
    logic                 ovf_clr;
    logic signed [OW-1:0] mix_o;
    logic                 mix_valid;
    logic                 ovf_sticky;
    logic                 misalign_sticky;
    logic [31:0]          mix_count;

    int     checks   = 0;
    int     failures = 0;
    longint exp_q[$];
    longint exp_cnt  = 0;
    longint last_out = 0;

    ddc_mixer #(.DW(DW), .NW(NW), .OW(OW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .clken           (clken),
        .adc_i           (adc_i),
        .adc_valid       (adc_valid),
        .nco_sin         (nco_sin),
        .nco_valid       (nco_valid),
        .ovf_clr         (ovf_clr),
        .mix_o           (mix_o),
        .mix_valid       (mix_valid),
        .ovf_sticky      (ovf_sticky),
        .misalign_sticky (misalign_sticky),
        .mix_count       (mix_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: exact product scaled by 2^-SH, rounded half toward +inf, clamped.
    function automatic longint model(input longint a, input longint b);
        real    x;
        longint r;
        longint hi;
        longint lo;
        x  = $floor(real'(a * b) / (2.0 ** SH) + 0.5);
        r  = longint'(x);
        hi = (longint'(1) << (OW - 1)) - 1;
        lo = -(longint'(1) << (OW - 1));
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    // Drive one cycle of inputs at the falling edge; record the expected result if accepted.
    task automatic cycle(input longint a, input longint b, input logic av, input logic nv,
                         input logic en, input logic clr);
        adc_i     = a[DW-1:0];
        nco_sin   = b[NW-1:0];
        adc_valid = av;
        nco_valid = nv;
        clken     = en;
        ovf_clr   = clr;
        if (reset_n && en && av && nv)
            exp_q.push_back(model(a, b));
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic clr);
        for (int i = 0; i < n; i++)
            cycle(0, 0, 1'b0, 1'b0, 1'b1, clr);
    endtask

    function automatic longint rand_word();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return -32768;
        if (sel == 1) return 32767;
        return longint'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Monitor: compares each fresh output against the scoreboard and checks holds otherwise.
    initial begin
        logic en_e;
        logic rn_e;
        forever begin
            @(posedge clk);
            en_e = clken;
            rn_e = reset_n;
            #1;
            if (!rn_e) begin
                exp_cnt  = 0;
                last_out = 0;
            end else if (en_e && mix_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_spurious: actual=mix_valid(%0d) required=no output at %0t",
                             mix_o, $time);
                end else begin
                    check("mon_value", mix_o, exp_q.pop_front());
                end
                exp_cnt++;
                check("mon_count", mix_count, exp_cnt);
                last_out = mix_o;
            end else begin
                check("mon_hold", mix_o, last_out);
                check("mon_cnt_hold", mix_count, exp_cnt);
            end
        end
    end

    initial begin
        longint c0;
        longint e;
        int     accepted;
        logic   av;
        logic   nv;

        reset_n   = 1'b0;
        clken     = 1'b0;
        adc_i     = '0;
        nco_sin   = '0;
        adc_valid = 1'b0;
        nco_valid = 1'b0;
        ovf_clr   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", mix_valid, 0);
        check("rst_mix_o", mix_o, 0);
        check("rst_count", mix_count, 0);
        check("rst_ovf", ovf_sticky, 0);
        check("rst_misalign", misalign_sticky, 0);
        reset_n = 1'b1;
        idle(1, 1'b0);

        // Basic product and exact latency.
        cycle(16384, 16384, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b0);
        check("lat_edge2_valid", mix_valid, 0);
        idle(1, 1'b0);
        check("lat_edge3_valid", mix_valid, 1);
        check("basic_value", mix_o, 8192);
        check("basic_count", mix_count, 1);
        idle(2, 1'b0);

        // Positive saturation, then clear.
        cycle(-32768, -32768, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b0);
        check("sat_value", mix_o, 32767);
        check("sat_ovf_set", ovf_sticky, 1);
        idle(1, 1'b1);
        check("sat_ovf_clr", ovf_sticky, 0);
        idle(2, 1'b0);

        // Half-up rounding at the tie point.
        cycle(1, 16384, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(-1, 16384, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b0);
        check("round_pos_half", mix_o, 1);
        idle(1, 1'b0);
        check("round_neg_half", mix_o, 0);
        check("round_no_ovf", ovf_sticky, 0);
        idle(2, 1'b0);

        // Stall for two cycles after S1.
        e = model(1000, -2000);
        cycle(1000, -2000, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check("stall_edge4_valid", mix_valid, 0);
        idle(1, 1'b0);
        check("stall_edge5_valid", mix_valid, 1);
        check("stall_value", mix_o, e);
        idle(2, 1'b0);

        // Unpaired sample is dropped and flagged.
        c0 = mix_count;
        cycle(123, 456, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b0);
        check("misalign_set", misalign_sticky, 1);
        check("misalign_count", mix_count, c0);
        idle(1, 1'b1);
        check("misalign_clr", misalign_sticky, 0);
        cycle(0, 77, 1'b0, 1'b1, 1'b1, 1'b1);
        check("misalign_set_wins", misalign_sticky, 1);
        idle(1, 1'b1);
        check("misalign_clr2", misalign_sticky, 0);
        cycle(5, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        check("misalign_gated", misalign_sticky, 0);
        idle(3, 1'b0);

        // Randomized traffic with stalls, gaps and occasional misalignment.
        for (int i = 0; i < 400; i++) begin
            av = ($urandom_range(0, 9) < 7);
            nv = av;
            if ($urandom_range(0, 19) == 0) nv = ~nv;
            cycle(rand_word(), rand_word(), av, nv,
                  ($urandom_range(0, 4) != 0), ($urandom_range(0, 29) == 0));
        end
        idle(4, 1'b0);

        // Reset in the middle of a continuous stream.
        accepted = 0;
        while (accepted < 4) begin
            cycle(rand_word(), rand_word(), 1'b1, 1'b1, 1'b1, 1'b0);
            accepted++;
        end
        reset_n = 1'b0;
        exp_q.delete();
        cycle(rand_word(), rand_word(), 1'b1, 1'b1, 1'b1, 1'b0);
        check("midrst_valid", mix_valid, 0);
        check("midrst_mix_o", mix_o, 0);
        check("midrst_count", mix_count, 0);
        check("midrst_ovf", ovf_sticky, 0);
        check("midrst_misalign", misalign_sticky, 0);
        reset_n = 1'b1;
        idle(3, 1'b0);
        check("postrst_no_valid", mix_valid, 0);
        check("postrst_count", mix_count, 0);
        for (int i = 0; i < 5; i++)
            cycle(rand_word(), rand_word(), 1'b1, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b0);
        check("postrst_stream_count", mix_count, 5);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            idle(1, 1'b0);
        check("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
